// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Opcodes, funct codes, mux selects and ALU operation codes live here.
package mips_mc_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;
    typedef logic [2:0] alucontrol_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BNE   = 6'b000101;

    localparam funct_t FN_ADD = 6'b100000;
    localparam funct_t FN_SUB = 6'b100010;
    localparam funct_t FN_AND = 6'b100100;
    localparam funct_t FN_OR  = 6'b100101;
    localparam funct_t FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam alucontrol_t ALU_AND = 3'b000;
    localparam alucontrol_t ALU_OR  = 3'b001;
    localparam alucontrol_t ALU_ADD = 3'b010;
    localparam alucontrol_t ALU_SUB = 3'b110;
    localparam alucontrol_t ALU_SLT = 3'b111;

    function automatic logic funct_supported(input funct_t f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and flags in, selects and enables out.
// master = controller side, slave = datapath side.
interface mips_mc_controller_if;
    import mips_mc_pkg::*;

    opcode_t     op;
    funct_t      funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        memwrite;
    logic        irwrite;
    logic        iord;
    logic        regdst;
    logic        memtoreg;
    logic        regwrite;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    alucontrol_t alucontrol;
    logic        pcen;
    logic        illegal;
    logic        mem_timeout;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal, mem_timeout
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal, mem_timeout
    );

endinterface

// File: rtl/mips_mc_controller_aludec.sv
// mc_aludec: maps the FSM's aluop (add/sub/funct) to the 3-bit ALU control.
// Latency: purely combinational; no flow control.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [1:0]  i_aluop,
    input  funct_t      i_funct,
    output alucontrol_t o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALU_ADD;
                    FN_SUB:  o_alucontrol = ALU_SUB;
                    FN_AND:  o_alucontrol = ALU_AND;
                    FN_OR:   o_alucontrol = ALU_OR;
                    FN_SLT:  o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM; outputs combinational from state; MC_BNE_EN adds bne decode.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready, aborting to FETCH after MEM_WAIT_MAX wait cycles.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mc_controller_if.master ctl
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;

    logic        w_mem_state;
    logic        w_timeout;
    logic        w_ne;
    logic        w_mem_req;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_iord;
    logic        w_regdst;
    logic        w_memtoreg;
    logic        w_regwrite;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [1:0]  w_pcsrc;
    logic [1:0]  w_aluop;
    logic        w_pcwrite;
    logic        w_branch;
    logic        w_illegal;
    alucontrol_t w_alucontrol;

    assign w_mem_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    // The wait that would push the counter to the limit is the last one; ready in that cycle still wins.
    assign w_timeout   = w_mem_state && !ctl.mem_ready && (r_wait_cnt == 8'(MEM_WAIT_MAX - 1));

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_iord       = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = SRCB_B;
        w_pcsrc      = PCSRC_ALU;
        w_aluop      = ALUOP_ADD;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = SRCB_FOUR;
                if (ctl.mem_ready) begin
                    w_irwrite    = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_alusrcb = SRCB_IMMSH;
                case (ctl.op)
                    OP_LW, OP_SW: w_state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct_supported(ctl.funct)) begin
                            w_state_next = EXECUTE;
                        end else begin
                            w_illegal    = 1'b1;
                            w_state_next = FETCH;
                        end
                    end
                    OP_BEQ:  w_state_next = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:  w_state_next = BRANCH;
`endif
                    OP_ADDI: w_state_next = ADDIEX;
                    OP_J:    w_state_next = JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = SRCB_IMM;
                w_state_next = (ctl.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (ctl.mem_ready)  w_state_next = MEMWB;
                else if (w_timeout) w_state_next = FETCH;
            end
            MEMWB: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_state_next = FETCH;
            end
            MEMWR: begin
                w_mem_req  = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (ctl.mem_ready || w_timeout) w_state_next = FETCH;
            end
            EXECUTE: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_FUNCT;
                w_state_next = ALUWB;
            end
            ALUWB: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_state_next = FETCH;
            end
            BRANCH: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_SUB;
                w_pcsrc      = PCSRC_ALUOUT;
                w_branch     = 1'b1;
                w_state_next = FETCH;
            end
            ADDIEX: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = SRCB_IMM;
                w_state_next = ADDIWB;
            end
            ADDIWB: begin
                w_regwrite   = 1'b1;
                w_state_next = FETCH;
            end
            JUMP: begin
                w_pcsrc      = PCSRC_JUMP;
                w_pcwrite    = 1'b1;
                w_state_next = FETCH;
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state && !ctl.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

`ifdef MC_BNE_EN
    logic r_ne;

    // Latched in DECODE because the branch compare happens a cycle later in BRANCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ne <= 1'b0;
        end else if (r_state == FETCH) begin
            r_ne <= 1'b0;
        end else if (r_state == DECODE) begin
            r_ne <= (ctl.op == OP_BNE);
        end
    end

    assign w_ne = r_ne;
`else
    assign w_ne = 1'b0;
`endif

    mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (ctl.funct),
        .o_alucontrol (w_alucontrol)
    );

    // Every output is forced low while reset is held, independent of the clock.
    assign ctl.mem_req     = reset & w_mem_req;
    assign ctl.memwrite    = reset & w_memwrite;
    assign ctl.irwrite     = reset & w_irwrite;
    assign ctl.iord        = reset & w_iord;
    assign ctl.regdst      = reset & w_regdst;
    assign ctl.memtoreg    = reset & w_memtoreg;
    assign ctl.regwrite    = reset & w_regwrite;
    assign ctl.alusrca     = reset & w_alusrca;
    assign ctl.alusrcb     = reset ? w_alusrcb    : 2'b00;
    assign ctl.pcsrc       = reset ? w_pcsrc      : 2'b00;
    assign ctl.alucontrol  = reset ? w_alucontrol : 3'b000;
    assign ctl.pcen        = reset & (w_pcwrite | (w_branch & (ctl.zero ^ w_ne)));
    assign ctl.illegal     = reset & w_illegal;
    assign ctl.mem_timeout = reset & w_timeout;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-instruction expected cycle traces from a behavioural model.
// Expected outputs are compared under a per-cycle care mask; MC_BNE_EN selects the bne expectation.
module tb_mips_mc_controller;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam int MAXW = 255;
`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ready;
        logic        zero;
        logic [17:0] exp;
        logic [17:0] care;
        logic [63:0] tag;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          tie_ready = 1'b0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    cyc_t        q[$];
    logic [17:0] obs;

    mips_mc_controller_if ctl();

    mips_mc_controller #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .ctl   (ctl)
    );

    always #5 clk = ~clk;

    assign obs = {ctl.mem_req, ctl.memwrite, ctl.irwrite, ctl.iord, ctl.regdst, ctl.memtoreg,
                  ctl.regwrite, ctl.alusrca, ctl.alusrcb, ctl.pcsrc, ctl.alucontrol,
                  ctl.pcen, ctl.illegal, ctl.mem_timeout};

    function automatic logic [17:0] pk(input logic mreq, input logic mw, input logic irw, input logic iord,
                                       input logic rdst, input logic m2r, input logic rw, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] pcs, input logic [2:0] alu,
                                       input logic pcen, input logic ill, input logic tmo);
        return {mreq, mw, irw, iord, rdst, m2r, rw, srca, srcb, pcs, alu, pcen, ill, tmo};
    endfunction

    // Write enables and pulses are always checked; selects only where they carry meaning.
    function automatic logic [17:0] cm(input logic iord, input logic rdst, input logic m2r, input logic srca,
                                       input logic srcb, input logic pcs, input logic alu);
        return pk(1, 1, 1, iord, rdst, m2r, 1, srca, {2{srcb}}, {2{pcs}}, {3{alu}}, 1, 1, 1);
    endfunction

    function automatic logic rb();
        return tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [63:0] tag, input logic r, input logic z,
                                 input logic [17:0] e, input logic [17:0] c);
        cyc_t x;
        x.op = cur_op; x.fn = cur_fn; x.ready = r; x.zero = z;
        x.exp = e; x.care = c; x.tag = tag;
        q.push_back(x);
    endfunction

    // A memory access of nwait stall cycles; at MAXW or more the last allowed stall times out.
    function automatic void mem_phase(input logic [63:0] tag, input int nwait, input logic [17:0] e_wait,
                                      input logic [17:0] e_done, input logic [17:0] c, output bit ok);
        int n = (nwait >= MAXW) ? MAXW - 1 : nwait;
        for (int i = 0; i < n; i++) push(tag, 1'b0, 1'($urandom_range(0, 1)), e_wait, c);
        if (nwait >= MAXW) begin
            push(tag, 1'b0, 1'($urandom_range(0, 1)), e_wait | 18'd1, c);
            ok = 1'b0;
        end else begin
            push(tag, 1'b1, 1'($urandom_range(0, 1)), e_done, c);
            ok = 1'b1;
        end
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                                      input int mw, input logic bz);
        bit ok;
        bit legal;
        cur_op = op;
        cur_fn = fn;
        mem_phase("FETCH", fw, pk(1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0),
                  pk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,1,0,0), cm(1,0,0,1,1,1,1), ok);
        if (!ok) return;
        legal = (op == T_R && fn_ok(fn)) || (op inside {T_LW, T_SW, T_BEQ, T_ADDI, T_J}) ||
                (BNE_EN && op == T_BNE);
        push("DECODE", rb(), 1'($urandom_range(0, 1)),
             pk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,!legal,0), cm(0,0,0,1,1,0,1));
        if (!legal) return;
        if (op == T_LW || op == T_SW) begin
            push("MEMADR", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0), cm(0,0,0,1,1,0,1));
            if (op == T_LW) begin
                mem_phase("MEMRD", mw, pk(1,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,0),
                          pk(1,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,0), cm(1,0,0,0,0,0,0), ok);
                if (ok) push("MEMWB", rb(), 1'($urandom_range(0, 1)),
                             pk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0,0), cm(0,1,1,0,0,0,0));
            end else begin
                mem_phase("MEMWR", mw, pk(1,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,0),
                          pk(1,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,0), cm(1,0,0,0,0,0,0), ok);
            end
        end else if (op == T_R) begin
            push("EXECUTE", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,0,0,0,1,2'b00,2'b00,alu_of(fn),0,0,0), cm(0,0,0,1,1,0,1));
            push("ALUWB", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0,0), cm(0,1,1,0,0,0,0));
        end else if (op == T_BEQ || op == T_BNE) begin
            push("BRANCH", rb(), bz,
                 pk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,bz ^ (op == T_BNE),0,0), cm(0,0,0,1,1,1,1));
        end else if (op == T_ADDI) begin
            push("ADDIEX", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0), cm(0,0,0,1,1,0,1));
            push("ADDIWB", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0,0), cm(0,1,1,0,0,0,0));
        end else begin
            push("JUMP", rb(), 1'($urandom_range(0, 1)),
                 pk(0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,0,0), cm(0,0,0,0,0,1,0));
        end
    endfunction

    // Entered just after a rising edge; drives one cycle of inputs and checks at the falling edge.
    task automatic run(input int n);
        cyc_t c;
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            c = q.pop_front();
            ctl.op = c.op; ctl.funct = c.fn; ctl.mem_ready = c.ready; ctl.zero = c.zero;
            @(negedge clk);
            cyc++;
            n_assert++;
            assert ((obs & c.care) === (c.exp & c.care)) else begin
                n_fail++;
                $error("FAIL %s cycle %0d: observed %b expected %b care %b", c.tag, cyc, obs, c.exp, c.care);
            end
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic check_zero(input logic [63:0] tag);
        n_assert++;
        assert (obs === 18'd0) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected all zero", tag, obs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fns [5];
        logic [5:0] op;
        logic [5:0] fn;
        int         mw;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        ctl.op = T_LW; ctl.funct = '0; ctl.mem_ready = 1'b1; ctl.zero = 1'b1;
        #2;
        check_zero("rst_init");
        @(posedge clk); #1;
        check_zero("rst_init_hold");
        rst_n = 1'b1;

        tie_ready = 1'b1;
        add_instr(T_R, 6'b100000, 0, 0, 1'b0);
        run(-1);
        tie_ready = 1'b0;

        add_instr(T_LW, 6'd0, 2, 2, 1'b0);  run(-1);
        add_instr(T_BEQ, 6'd0, 0, 0, 1'b1); run(-1);
        add_instr(T_BEQ, 6'd0, 0, 0, 1'b0); run(-1);
        add_instr(T_SW, 6'd0, 0, 255, 1'b0); run(-1);
        add_instr(T_SW, 6'd0, 0, 254, 1'b0); run(-1);
        add_instr(T_LW, 6'd0, 1, 300, 1'b0); run(-1);
        add_instr(T_ADDI, 6'd0, 255, 0, 1'b0); run(-1);
        add_instr(T_BNE, 6'd0, 0, 0, 1'b0); run(-1);
        add_instr(T_BEQ, 6'd0, 0, 0, 1'b1); run(-1);
        add_instr(T_R, 6'b000000, 0, 0, 1'b0); run(-1);
        add_instr(T_J, 6'd0, 1, 0, 1'b0); run(-1);

        // Reset dropped asynchronously while a load waits in MEMRD.
        add_instr(T_LW, 6'd0, 0, 10, 1'b0);
        run(5);
        q.delete();
        ctl.mem_ready = 1'b1; ctl.zero = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_held");
        rst_n = 1'b1;
        add_instr(T_ADDI, 6'd0, 1, 0, 1'b0);
        run(-1);

        for (int i = 0; i < 80; i++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 8))
                0: begin op = T_R; fn = fns[$urandom_range(0, 4)]; end
                1: op = T_R;
                2: op = T_LW;
                3: op = T_SW;
                4: op = T_BEQ;
                5: op = T_ADDI;
                6: op = T_J;
                7: op = T_BNE;
                default: op = 6'($urandom_range(0, 63));
            endcase
            mw = ($urandom_range(0, 15) == 0) ? 253 + $urandom_range(0, 3) : $urandom_range(0, 4);
            add_instr(op, fn, $urandom_range(0, 3), mw, 1'($urandom_range(0, 1)));
            run(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
